vmul_issue_ctrl: RTL and testbench

Issue-side controller for the 8-bit-lane vector multiply datapath. It accepts one operand-pair request per transaction over a valid/ready handshake and drives the datapath's sew, start, count_0 and operand inputs for the pass sequence the element width requires. It waits the datapath's fixed latency, captures product_1..4 into a result register and returns them over a valid/ready handshake. It sits between the vector execute dispatcher and the multiplier datapath.

---
 rtl/vmul_issue_ctrl_if.sv | 50 +++++
 rtl/vmul_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_vmul_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmul_issue_ctrl_if.sv
// Handshake and datapath bundle between the vector dispatcher, the issue
// controller and the 8-bit-lane multiplier datapath.
interface vmul_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sew;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [31:0] req_a2;
  logic [31:0] req_b2;
  logic [1:0]  mul_sew;
  logic        mul_start;
  logic        mul_count_0;
  logic [31:0] mul_a1;
  logic [31:0] mul_b1;
  logic [31:0] mul_a2;
  logic [31:0] mul_b2;
  logic [31:0] mul_product_1;
  logic [31:0] mul_product_2;
  logic [31:0] mul_product_3;
  logic [31:0] mul_product_4;
  logic        res_valid;
  logic        res_ready;
  logic        res_err;
  logic [31:0] res_p1;
  logic [31:0] res_p2;
  logic [31:0] res_p3;
  logic [31:0] res_p4;
  logic        busy;

  modport master (
    output req_valid, req_sew, req_a1, req_b1, req_a2, req_b2,
    input  req_ready,
    input  mul_sew, mul_start, mul_count_0, mul_a1, mul_b1, mul_a2, mul_b2,
    output mul_product_1, mul_product_2, mul_product_3, mul_product_4,
    input  res_valid, res_err, res_p1, res_p2, res_p3, res_p4,
    output res_ready,
    input  busy
  );

  modport slave (
    input  req_valid, req_sew, req_a1, req_b1, req_a2, req_b2,
    output req_ready,
    output mul_sew, mul_start, mul_count_0, mul_a1, mul_b1, mul_a2, mul_b2,
    input  mul_product_1, mul_product_2, mul_product_3, mul_product_4,
    output res_valid, res_err, res_p1, res_p2, res_p3, res_p4,
    input  res_ready,
    output busy
  );
endinterface

// File: rtl/vmul_issue_ctrl.sv
// Issue controller for the vector multiply datapath: sequences the issue
// passes, waits out the datapath latency and returns the captured products.
module vmul_issue_ctrl #(
  parameter int MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset,
  vmul_issue_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    ISSUE1 = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(MUL_LATENCY - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        capture_s;
  logic        release_s;
  logic [3:0]  wait_cnt_r;
  logic        req_ready_r;
  logic        busy_r;
  logic        mul_start_r;
  logic        mul_count_0_r;
  // The mul_* operand registers double as the request holding registers.
  logic [1:0]  mul_sew_r;
  logic [31:0] mul_a1_r;
  logic [31:0] mul_b1_r;
  logic [31:0] mul_a2_r;
  logic [31:0] mul_b2_r;
  logic        res_valid_r;
  logic        res_err_r;
  logic [31:0] res_p1_r;
  logic [31:0] res_p2_r;
  logic [31:0] res_p3_r;
  logic [31:0] res_p4_r;

  // Next-state decode and the accept/capture/release strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          accept_s     = 1'b1;
          next_state_s = (bus.req_sew == 2'd3) ? RESP : ISSUE0;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE0: begin
        if (mul_sew_r == 2'd2) begin
          next_state_s = ISSUE1;
        end else begin
          next_state_s = WAIT;
        end
      end
      ISSUE1: next_state_s = WAIT;
      WAIT: begin
        if (wait_cnt_r == LAST_WAIT) begin
          capture_s    = 1'b1;
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          release_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, wait counter and the control outputs registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      wait_cnt_r    <= 4'd0;
      req_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      mul_start_r   <= 1'b0;
      mul_count_0_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      wait_cnt_r    <= ((state_r == WAIT) && (next_state_s == WAIT)) ? (wait_cnt_r + 4'd1) : 4'd0;
      req_ready_r   <= (next_state_s == IDLE);
      busy_r        <= (next_state_s != IDLE);
      mul_start_r   <= (next_state_s == ISSUE0);
      mul_count_0_r <= (next_state_s == ISSUE0);
    end
  end

  // Operand hold from acceptance until the products are captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_sew_r <= 2'd0;
      mul_a1_r  <= 32'd0;
      mul_b1_r  <= 32'd0;
      mul_a2_r  <= 32'd0;
      mul_b2_r  <= 32'd0;
    end else if (accept_s && (bus.req_sew != 2'd3)) begin
      mul_sew_r <= bus.req_sew;
      mul_a1_r  <= bus.req_a1;
      mul_b1_r  <= bus.req_b1;
      mul_a2_r  <= bus.req_a2;
      mul_b2_r  <= bus.req_b2;
    end else if (capture_s) begin
      mul_sew_r <= 2'd0;
      mul_a1_r  <= 32'd0;
      mul_b1_r  <= 32'd0;
      mul_a2_r  <= 32'd0;
      mul_b2_r  <= 32'd0;
    end
  end

  // Result register: illegal sew answers at once with zero data, products are sampled once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_r <= 1'b0;
      res_err_r   <= 1'b0;
      res_p1_r    <= 32'd0;
      res_p2_r    <= 32'd0;
      res_p3_r    <= 32'd0;
      res_p4_r    <= 32'd0;
    end else if (accept_s && (bus.req_sew == 2'd3)) begin
      res_valid_r <= 1'b1;
      res_err_r   <= 1'b1;
      res_p1_r    <= 32'd0;
      res_p2_r    <= 32'd0;
      res_p3_r    <= 32'd0;
      res_p4_r    <= 32'd0;
    end else if (capture_s) begin
      res_valid_r <= 1'b1;
      res_err_r   <= 1'b0;
      res_p1_r    <= bus.mul_product_1;
      res_p2_r    <= bus.mul_product_2;
      res_p3_r    <= bus.mul_product_3;
      res_p4_r    <= bus.mul_product_4;
    end else if (release_s) begin
      res_valid_r <= 1'b0;
      res_err_r   <= 1'b0;
    end
  end

  assign bus.req_ready   = req_ready_r;
  assign bus.busy        = busy_r;
  assign bus.mul_start   = mul_start_r;
  assign bus.mul_count_0 = mul_count_0_r;
  assign bus.mul_sew     = mul_sew_r;
  assign bus.mul_a1      = mul_a1_r;
  assign bus.mul_b1      = mul_b1_r;
  assign bus.mul_a2      = mul_a2_r;
  assign bus.mul_b2      = mul_b2_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_err     = res_err_r;
  assign bus.res_p1      = res_p1_r;
  assign bus.res_p2      = res_p2_r;
  assign bus.res_p3      = res_p3_r;
  assign bus.res_p4      = res_p4_r;

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
// Randomised and directed bench for vmul_issue_ctrl with a transaction-timing
// reference model and a stub datapath whose products are logged per cycle.
module tb_vmul_issue_ctrl;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vmul_issue_ctrl_if bus ();

  vmul_issue_ctrl #(.MUL_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int mode        = 0;  // stub: 0 random, 1 fixed 0x11..0x44, 2 low word of a1*b1
  logic [127:0] prod_hist [int];

  // model of the single in-flight transaction
  bit          m_act = 1'b0;
  int          m_t0  = 0;
  logic [1:0]  m_sew = 2'd0;
  logic [31:0] m_a1, m_b1, m_a2, m_b2;
  logic [31:0] m_p [4];
  int          m_lc, m_rc;
  bit          m_resp, m_issue, m_first;
  logic [31:0] m_rp [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_to(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout, expected event by cycle %0d", name, cyc);
  endtask

  // stub datapath, products logged for the model
  always @(posedge clk) begin
    logic [31:0] p1, p2, p3, p4;
    #1;
    case (mode)
      1: begin p1 = 32'h11; p2 = 32'h22; p3 = 32'h33; p4 = 32'h44; end
      2: begin p1 = bus.mul_a1 * bus.mul_b1; p2 = 32'd0; p3 = 32'd0; p4 = 32'd0; end
      default: begin p1 = $urandom; p2 = $urandom; p3 = $urandom; p4 = $urandom; end
    endcase
    bus.mul_product_1 = p1;
    bus.mul_product_2 = p2;
    bus.mul_product_3 = p3;
    bus.mul_product_4 = p4;
    prod_hist[cyc] = {p4, p3, p2, p1};
  end

  // reference model and per-cycle compare
  always @(negedge clk) begin
    if (reset) begin
      m_act = 1'b0;
      for (int k = 0; k < 4; k++) m_p[k] = 32'd0;
    end
    m_lc    = m_t0 + ((m_sew == 2'd2) ? 2 : 1);
    m_rc    = (m_sew == 2'd3) ? (m_t0 + 1) : (m_lc + LAT + 1);
    m_resp  = m_act && (cyc >= m_rc);
    m_issue = m_act && (m_sew != 2'd3) && (cyc > m_t0) && (cyc <= m_lc + LAT);
    m_first = m_issue && (cyc == m_t0 + 1);
    for (int k = 0; k < 4; k++)
      m_rp[k] = (m_sew == 2'd3 || !m_resp) ? 32'd0 : prod_hist[m_lc + LAT][32*k +: 32];
    chk("req_ready", bus.req_ready, {31'd0, !m_act});
    chk("busy", bus.busy, {31'd0, m_act});
    chk("res_valid", bus.res_valid, {31'd0, m_resp});
    chk("res_err", bus.res_err, {31'd0, m_resp && (m_sew == 2'd3)});
    chk("mul_start", bus.mul_start, {31'd0, m_first});
    chk("mul_count_0", bus.mul_count_0, {31'd0, m_first});
    chk("mul_sew", bus.mul_sew, m_issue ? {30'd0, m_sew} : 32'd0);
    chk("mul_a1", bus.mul_a1, m_issue ? m_a1 : 32'd0);
    chk("mul_b1", bus.mul_b1, m_issue ? m_b1 : 32'd0);
    chk("mul_a2", bus.mul_a2, m_issue ? m_a2 : 32'd0);
    chk("mul_b2", bus.mul_b2, m_issue ? m_b2 : 32'd0);
    chk("res_p1", bus.res_p1, m_resp ? m_rp[0] : m_p[0]);
    chk("res_p2", bus.res_p2, m_resp ? m_rp[1] : m_p[1]);
    chk("res_p3", bus.res_p3, m_resp ? m_rp[2] : m_p[2]);
    chk("res_p4", bus.res_p4, m_resp ? m_rp[3] : m_p[3]);
    if (!reset) begin
      if (!m_act && bus.req_valid) begin
        m_act = 1'b1;
        m_t0  = cyc;
        m_sew = bus.req_sew;
        m_a1  = bus.req_a1;
        m_b1  = bus.req_b1;
        m_a2  = bus.req_a2;
        m_b2  = bus.req_b2;
      end else if (m_resp && bus.res_ready) begin
        m_act = 1'b0;
        for (int k = 0; k < 4; k++) m_p[k] = m_rp[k];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [31:0] a2, input logic [31:0] b2);
    bus.req_valid = v;
    bus.req_sew   = s;
    bus.req_a1    = a1;
    bus.req_b1    = b1;
    bus.req_a2    = a2;
    bus.req_b2    = b2;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    if (!ok) fail_to("wait_idle");
    tick();
  endtask

  task automatic wait_res(input string name, output int rc);
    rc = -1;
    for (int i = 0; i < 40 && rc < 0; i++) begin
      @(negedge clk);
      if (bus.res_valid) rc = cyc;
    end
    if (rc < 0) fail_to(name);
  endtask

  initial begin
    int t, rc, h, s, n;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    bus.res_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // sew=0 with fixed stub products
    mode = 1;
    drive(1'b1, 2'd0, 32'h01020304, 32'h05060708, $urandom, $urandom);
    t = cyc;
    tick();
    bus.req_valid = 1'b0;
    goto_neg(t + 1);
    chk("A_start", bus.mul_start, 32'd1);
    chk("A_count_0", bus.mul_count_0, 32'd1);
    goto_neg(t + 2);
    chk("A_start_once", bus.mul_start, 32'd0);
    wait_res("A_res_valid", rc);
    chk("A_latency", rc, t + 5);
    chk("A_p1", bus.res_p1, 32'h11);
    chk("A_p2", bus.res_p2, 32'h22);
    chk("A_p3", bus.res_p3, 32'h33);
    chk("A_p4", bus.res_p4, 32'h44);
    chk("A_err", bus.res_err, 32'd0);

    // sew=2, two issue passes
    wait_idle();
    mode = 2;
    drive(1'b1, 2'd2, 32'd7, 32'hFFFFFFFD, $urandom, $urandom);
    t = cyc;
    tick();
    bus.req_valid = 1'b0;
    goto_neg(t + 1);
    chk("B_start", bus.mul_start, 32'd1);
    chk("B_count_0", bus.mul_count_0, 32'd1);
    goto_neg(t + 2);
    chk("B_start_p2", bus.mul_start, 32'd0);
    chk("B_count_0_p2", bus.mul_count_0, 32'd0);
    goto_neg(t + 5);
    chk("B_a1_hold", bus.mul_a1, 32'd7);
    chk("B_b1_hold", bus.mul_b1, 32'hFFFFFFFD);
    wait_res("B_res_valid", rc);
    chk("B_latency", rc, t + 6);
    chk("B_p1", bus.res_p1, 32'hFFFFFFEB);

    // illegal sew
    wait_idle();
    mode = 0;
    drive(1'b1, 2'd3, $urandom, $urandom, $urandom, $urandom);
    t = cyc;
    tick();
    bus.req_valid = 1'b0;
    wait_res("C_res_valid", rc);
    chk("C_latency", rc, t + 1);
    chk("C_err", bus.res_err, 32'd1);
    chk("C_p1", bus.res_p1, 32'd0);
    chk("C_p4", bus.res_p4, 32'd0);

    // result stalled with changing products
    wait_idle();
    bus.res_ready = 1'b0;
    drive(1'b1, 2'd1, $urandom, $urandom, $urandom, $urandom);
    tick();
    bus.req_valid = 1'b0;
    wait_res("D_res_valid", rc);
    repeat (10) @(negedge clk);
    chk("D_still_valid", bus.res_valid, 32'd1);
    tick();
    bus.res_ready = 1'b1;
    h = cyc;
    goto_neg(h + 1);
    chk("D_req_ready", bus.req_ready, 32'd1);
    chk("D_busy", bus.busy, 32'd0);

    // reset in the middle of WAIT
    wait_idle();
    drive(1'b1, 2'd2, $urandom, $urandom, $urandom, $urandom);
    t = cyc;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    goto_neg(t + 4);
    chk("E_req_ready", bus.req_ready, 32'd1);
    chk("E_busy", bus.busy, 32'd0);
    chk("E_start", bus.mul_start, 32'd0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_valid) n++;
    end
    chk("E_no_result", n, 32'd0);

    // back-to-back with req_valid held high
    tick();
    drive(1'b1, 2'd0, $urandom, $urandom, $urandom, $urandom);
    wait_res("F_res_valid", h);
    s = -1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      @(negedge clk);
      if (bus.mul_start) s = cyc;
    end
    if (s < 0) fail_to("F_second_start");
    else chk("F_reaccept", s, h + 2);
    tick();
    bus.req_valid = 1'b0;

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
      bus.res_ready = ($urandom_range(0, 9) < 6);
    end
    tick();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
